uc_arbiter_rr: RTL and testbench

Parametrised unit-clause (UC) arbiter for the multi-engine SAT datapath. It accepts UC literals from the memory loader during the load phase and from `NUM_ENGINE` BCP engines during the run phase. Each literal is checked against a per-variable polarity table: new literals are queued, duplicates are dropped, and opposite-polarity hits raise a sticky conflict. Queued literals are re-broadcast to the engines through an output FIFO with a per-literal destination mask. The block sits between the loader/engines and the engine receive FIFOs.

---
 rtl/uc_arbiter_rr_pkg.sv | 34 +++
 rtl/uc_arbiter_rr_if.sv | 43 ++++
 rtl/uc_arbiter_rr_fifo.sv | 75 +++++++
 rtl/uc_arbiter_rr.sv | 178 +++++++++++++++++
 tb/tb_uc_arbiter_rr.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uc_arbiter_rr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uc_pkg
//  Brief    : Shared types and helpers for the unit-clause arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package uc_pkg;

    typedef enum logic [2:0] {
        CLEAR    = 3'd0,
        IDLE     = 3'd1,
        LOAD     = 3'd2,
        RUN      = 3'd3,
        CONFLICT = 3'd4
    } uc_arb_state_t;

    // Literals are carried in a wide container; the real width is VAR_W+1.
    localparam int c_LIT_MAX_W = 32;
    typedef logic [c_LIT_MAX_W-1:0] uc_lit_t;

    // Polarity-table entry bits.
    localparam int c_TBL_POS = 0;
    localparam int c_TBL_NEG = 1;

    function automatic uc_lit_t lit_var(input uc_lit_t lit, input int var_w);
        return lit & ((uc_lit_t'(1) << var_w) - uc_lit_t'(1));
    endfunction

    function automatic logic lit_neg(input uc_lit_t lit, input int var_w);
        return lit[var_w];
    endfunction

endpackage
`default_nettype wire

// File: rtl/uc_arbiter_rr_if.sv
`default_nettype none
// ============================================================================
//  Module   : uc_arbiter_rr_if
//  Brief    : Loader / engine / broadcast handshake bundle of the UC arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface uc_arbiter_rr_if #(
    parameter int NUM_VARS   = 1024,
    parameter int NUM_ENGINE = 4
);
    localparam int VAR_W = $clog2(NUM_VARS);
    localparam int LIT_W = VAR_W + 1;

    logic                                  clear;
    logic                                  mem_valid;
    logic                                  mem_ready;
    logic [LIT_W-1:0]                      mem_lit;
    logic                                  mem_done;
    logic [NUM_ENGINE-1:0]                 eng_valid;
    logic [NUM_ENGINE-1:0]                 eng_ready;
    logic [NUM_ENGINE-1:0][LIT_W-1:0]      eng_lit;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [LIT_W-1:0]                      out_lit;
    logic [NUM_ENGINE-1:0]                 out_engmask;
    logic                                  conflict;
    logic [VAR_W-1:0]                      conflict_var;
    logic                                  busy;

    modport master (
        output clear, mem_valid, mem_lit, mem_done, eng_valid, eng_lit, out_ready,
        input  mem_ready, eng_ready, out_valid, out_lit, out_engmask,
               conflict, conflict_var, busy
    );

    modport slave (
        input  clear, mem_valid, mem_lit, mem_done, eng_valid, eng_lit, out_ready,
        output mem_ready, eng_ready, out_valid, out_lit, out_engmask,
               conflict, conflict_var, busy
    );

endinterface
`default_nettype wire

// File: rtl/uc_arbiter_rr_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uc_fifo
//  Brief    : Synchronous FIFO with flush; push while full is legal with a pop.
//  Revision : 1.0  initial release
// ============================================================================
module uc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          i_flush,
    input  wire logic                          i_push,
    input  wire logic [WIDTH-1:0]              i_push_data,
    input  wire logic                          i_pop,
    output logic      [WIDTH-1:0]              o_pop_data,
    output logic                               o_full,
    output logic                               o_empty,
    output logic      [$clog2(DEPTH+1)-1:0]    o_count
);
    localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W  = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    function automatic logic [c_ADDR_W-1:0] ptr_inc(input logic [c_ADDR_W-1:0] p);
        return (p == c_ADDR_W'(DEPTH - 1)) ? '0 : p + c_ADDR_W'(1);
    endfunction

    assign w_full    = (r_count == c_CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~w_empty & ~i_flush;
    assign w_do_push = i_push & (~w_full | w_do_pop) & ~i_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_pop_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;

endmodule
`default_nettype wire

// File: rtl/uc_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : uc_arbiter_rr
//  Brief    : Unit-clause arbiter: polarity-table filter, RR engine grant, broadcast FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module uc_arbiter_rr
    import uc_pkg::*;
#(
    parameter int NUM_VARS   = 1024,
    parameter int NUM_ENGINE = 4,
    parameter int FIFO_DEPTH = 64
) (
    input  wire logic           clk,
    input  wire logic           rst,
    uc_arbiter_rr_if.slave      bus
);
    localparam int VAR_W        = $clog2(NUM_VARS);
    localparam int LIT_W        = VAR_W + 1;
    localparam int c_PTR_W      = $clog2(NUM_ENGINE);
    localparam int c_FIFO_W     = LIT_W + NUM_ENGINE;
    localparam int c_CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [VAR_W-1:0] c_SWEEP_LAST = VAR_W'(NUM_VARS - 1);

    uc_arb_state_t        r_state;
    logic [VAR_W-1:0]     r_sweep_cnt;
    logic [c_PTR_W-1:0]   r_rr_ptr;
    logic                 r_conflict;
    logic [VAR_W-1:0]     r_conflict_var;
    logic                 r_busy;
    logic [1:0]           r_table [NUM_VARS];

    logic                  w_full;
    logic                  w_empty;
    logic [c_CNT_W-1:0]    w_count;
    logic [c_FIFO_W-1:0]   w_fifo_dout;
    logic                  w_out_valid;
    logic                  w_pop;
    logic                  w_can_acc;
    logic                  w_mem_ready;
    logic                  w_gnt_any;
    logic [c_PTR_W-1:0]    w_gnt_idx;
    logic [NUM_ENGINE-1:0] w_eng_ready;
    logic                  w_mem_acc;
    logic                  w_eng_acc;
    logic                  w_acc;
    logic [LIT_W-1:0]      w_acc_lit;
    logic [NUM_ENGINE-1:0] w_acc_mask;
    logic [VAR_W-1:0]      w_acc_var;
    logic                  w_acc_neg;
    logic [1:0]            w_entry;
    logic [1:0]            w_set_bit;
    logic                  w_dup;
    logic                  w_opp;
    logic                  w_hit_conflict;
    logic                  w_push;
    logic                  w_flush;
    logic                  w_unused;

    // A pop frees a slot in the same cycle, so readiness looks through it.
    assign w_out_valid = ~w_empty & (r_state != CONFLICT);
    assign w_pop       = w_out_valid & bus.out_ready;
    assign w_can_acc   = (~w_full | w_pop) & ~bus.clear;
    assign w_mem_ready = (r_state == LOAD) & w_can_acc;

    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_ENGINE; k++) begin
            if (!w_gnt_any && bus.eng_valid[(int'(r_rr_ptr) + k) % NUM_ENGINE]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = c_PTR_W'((int'(r_rr_ptr) + k) % NUM_ENGINE);
            end
        end
    end

    assign w_eng_ready = ((r_state == RUN) && w_can_acc && w_gnt_any)
                         ? (NUM_ENGINE'(1) << w_gnt_idx) : '0;

    assign w_mem_acc  = bus.mem_valid & w_mem_ready;
    assign w_eng_acc  = |(bus.eng_valid & w_eng_ready);
    assign w_acc      = w_mem_acc | w_eng_acc;
    assign w_acc_lit  = w_mem_acc ? bus.mem_lit : bus.eng_lit[w_gnt_idx];
    assign w_acc_mask = w_mem_acc ? '1 : ~(NUM_ENGINE'(1) << w_gnt_idx);
    assign w_acc_var  = VAR_W'(lit_var(uc_lit_t'(w_acc_lit), VAR_W));
    assign w_acc_neg  = lit_neg(uc_lit_t'(w_acc_lit), VAR_W);

    // Single read-modify-write of the accepted literal's entry.
    assign w_entry        = r_table[w_acc_var];
    assign w_dup          = w_acc_neg ? w_entry[c_TBL_NEG] : w_entry[c_TBL_POS];
    assign w_opp          = w_acc_neg ? w_entry[c_TBL_POS] : w_entry[c_TBL_NEG];
    assign w_set_bit      = w_acc_neg ? 2'(1 << c_TBL_NEG) : 2'(1 << c_TBL_POS);
    assign w_hit_conflict = w_acc & ~w_dup & w_opp;
    assign w_push         = w_acc & ~w_dup & ~w_opp;
    assign w_flush        = bus.clear | w_hit_conflict | (r_state == CONFLICT);

    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_table[r_sweep_cnt] <= '0;
        end else if (w_push) begin
            r_table[w_acc_var] <= w_entry | w_set_bit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= CLEAR;
            r_sweep_cnt    <= '0;
            r_rr_ptr       <= '0;
            r_conflict     <= 1'b0;
            r_conflict_var <= '0;
            r_busy         <= 1'b1;
        end else begin
            if (w_eng_acc) begin
                r_rr_ptr <= (w_gnt_idx == c_PTR_W'(NUM_ENGINE - 1)) ? '0 : w_gnt_idx + c_PTR_W'(1);
            end
            if (bus.clear) begin
                r_state        <= CLEAR;
                r_sweep_cnt    <= '0;
                r_conflict     <= 1'b0;
                r_conflict_var <= '0;
                r_busy         <= 1'b1;
            end else if (w_hit_conflict) begin
                r_state        <= CONFLICT;
                r_conflict     <= 1'b1;
                r_conflict_var <= w_acc_var;
            end else begin
                case (r_state)
                    CLEAR: begin
                        r_sweep_cnt <= r_sweep_cnt + VAR_W'(1);
                        if (r_sweep_cnt == c_SWEEP_LAST) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    IDLE:     r_state <= LOAD;
                    LOAD:     if (bus.mem_done && !w_mem_acc) r_state <= RUN;
                    RUN:      r_state <= RUN;
                    CONFLICT: r_state <= CONFLICT;
                    default: begin
                        r_state     <= CLEAR;
                        r_sweep_cnt <= '0;
                        r_busy      <= 1'b1;
                    end
                endcase
            end
        end
    end

    uc_fifo #(
        .WIDTH (c_FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (w_flush),
        .i_push      (w_push),
        .i_push_data ({w_acc_lit, w_acc_mask}),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_dout),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    assign w_unused = ^w_count;

    assign bus.mem_ready    = w_mem_ready;
    assign bus.eng_ready    = w_eng_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_lit      = w_fifo_dout[c_FIFO_W-1:NUM_ENGINE];
    assign bus.out_engmask  = w_fifo_dout[NUM_ENGINE-1:0];
    assign bus.conflict     = r_conflict;
    assign bus.conflict_var = r_conflict_var;
    assign bus.busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uc_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uc_arbiter_rr
//  Brief    : Scoreboard bench for uc_arbiter_rr (16 vars, 4 engines, 4-deep FIFO).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uc_arbiter_rr;
    localparam int NV = 16;
    localparam int NE = 4;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uc_arbiter_rr_if #(.NUM_VARS(NV), .NUM_ENGINE(NE)) bus ();

    uc_arbiter_rr #(
        .NUM_VARS   (NV),
        .NUM_ENGINE (NE),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         n_out = 0;
    logic [8:0] sb_q [$];
    logic [8:0] m_exp;
    logic [1:0] m_tbl [NV];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference polarity table: push only genuinely new literals.
    task automatic model_accept(input logic [4:0] lit, input logic [3:0] mask);
        logic [3:0] v;
        logic       n;
        v = lit[3:0];
        n = lit[4];
        if (m_tbl[v][n]) begin
        end else if (m_tbl[v][~n]) begin
            sb_q.delete();
        end else begin
            m_tbl[v][n] = 1'b1;
            sb_q.push_back({lit, mask});
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) m_tbl[i] = 2'b00;
        sb_q.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.busy) n++;
            else break;
        end
    endtask

    task automatic mem_send(input logic [4:0] lit);
        int t;
        t = 0;
        bus.mem_valid = 1'b1;
        bus.mem_lit   = lit;
        @(negedge clk);
        while (!bus.mem_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("mem_accept", 32'(bus.mem_ready), 32'd1);
        if (bus.mem_ready) model_accept(lit, 4'hF);
        step();
        bus.mem_valid = 1'b0;
    endtask

    task automatic eng_send(input int i, input logic [4:0] lit);
        int t;
        t = 0;
        bus.eng_valid[i] = 1'b1;
        bus.eng_lit[i]   = lit;
        @(negedge clk);
        while (!bus.eng_ready[i] && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("eng_accept", 32'(bus.eng_ready[i]), 32'd1);
        if (bus.eng_ready[i]) model_accept(lit, 4'hF & ~(4'(1) << i));
        step();
        bus.eng_valid[i] = 1'b0;
    endtask

    // Output monitor: every completed handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            n_out++;
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", 32'(sb_q.size()), 32'd1);
            end else begin
                m_exp = sb_q.pop_front();
                chk("out_lit", 32'(bus.out_lit), 32'(m_exp[8:4]));
                chk("out_mask", 32'(bus.out_engmask), 32'(m_exp[3:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int n0;
        bus.clear     = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_lit   = '0;
        bus.mem_done  = 1'b0;
        bus.eng_valid = '0;
        bus.eng_lit   = '0;
        bus.out_ready = 1'b1;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy",      32'(bus.busy),         32'd1);
        chk("rst_mem_ready", 32'(bus.mem_ready),    32'd0);
        chk("rst_eng_ready", 32'(bus.eng_ready),    32'd0);
        chk("rst_out_valid", 32'(bus.out_valid),    32'd0);
        chk("rst_out_lit",   32'(bus.out_lit),      32'd0);
        chk("rst_out_mask",  32'(bus.out_engmask),  32'd0);
        chk("rst_conflict",  32'(bus.conflict),     32'd0);
        chk("rst_cvar",      32'(bus.conflict_var), 32'd0);
        step();
        rst = 1'b1;
        count_busy(n);
        chk("rst_sweep_len", 32'(n), 32'd16);
        chk("idle_mem_ready", 32'(bus.mem_ready), 32'd0);
        step();

        // First literal, one-cycle latency
        mem_send(5'd5);
        @(negedge clk);
        chk("first_valid", 32'(bus.out_valid),   32'd1);
        chk("first_lit",   32'(bus.out_lit),     32'd5);
        chk("first_mask",  32'(bus.out_engmask), 32'hF);
        step();

        // Back-to-back duplicate
        n0 = n_out;
        mem_send(5'd3);
        mem_send(5'd3);
        repeat (4) step();
        chk("dup_outputs", 32'(n_out - n0), 32'd1);

        // Into RUN; loader no longer served
        bus.mem_done = 1'b1;
        repeat (2) step();
        bus.mem_valid = 1'b1;
        bus.mem_lit   = 5'd6;
        @(negedge clk);
        chk("run_mem_ready", 32'(bus.mem_ready), 32'd0);
        step();
        bus.mem_valid = 1'b0;

        // Round-robin across four simultaneous engines
        for (int k = 0; k < NE; k++) bus.eng_lit[k] = 5'(8 + k);
        bus.eng_valid = 4'hF;
        for (int k = 0; k < NE; k++) begin
            @(negedge clk);
            chk("rr_grant", 32'(bus.eng_ready), 32'(1) << k);
            model_accept(5'(8 + k), 4'hF & ~(4'(1) << k));
            step();
            bus.eng_valid[k] = 1'b0;
        end
        repeat (3) step();
        chk("rr_drain", 32'(sb_q.size()), 32'd0);

        // Conflict with a pending output that must be flushed
        bus.out_ready = 1'b0;
        eng_send(1, 5'd7);
        eng_send(2, 5'h17);
        @(negedge clk);
        chk("cf_flag",      32'(bus.conflict),     32'd1);
        chk("cf_var",       32'(bus.conflict_var), 32'd7);
        chk("cf_out_valid", 32'(bus.out_valid),    32'd0);
        step();
        bus.out_ready = 1'b1;
        bus.mem_valid = 1'b1;
        bus.eng_valid = 4'hF;
        repeat (3) begin
            @(negedge clk);
            chk("cf_mem_ready", 32'(bus.mem_ready), 32'd0);
            chk("cf_eng_ready", 32'(bus.eng_ready), 32'd0);
            step();
        end
        bus.mem_valid = 1'b0;
        bus.eng_valid = '0;
        bus.mem_done  = 1'b0;
        bus.clear     = 1'b1;
        step();
        bus.clear     = 1'b0;
        model_reset();
        count_busy(n);
        chk("cf_sweep_len", 32'(n), 32'd16);
        chk("cf_cleared",   32'(bus.conflict), 32'd0);
        step();

        // Backpressure: fill, stall, single pop admits exactly one
        bus.out_ready = 1'b0;
        mem_send(5'd1);
        mem_send(5'd2);
        mem_send(5'd4);
        mem_send(5'd6);
        bus.mem_valid = 1'b1;
        bus.mem_lit   = 5'd12;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready_low", 32'(bus.mem_ready), 32'd0);
            chk("bp_head",      32'(bus.out_lit),   32'd1);
            step();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_ready", 32'(bus.mem_ready), 32'd1);
        model_accept(5'd12, 4'hF);
        step();
        bus.out_ready = 1'b0;
        bus.mem_lit   = 5'd13;
        @(negedge clk);
        chk("bp_refull", 32'(bus.mem_ready), 32'd0);
        step();
        bus.mem_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) step();
        chk("bp_drain", 32'(sb_q.size()), 32'd0);

        // Clear mid-LOAD with a full FIFO
        bus.out_ready = 1'b0;
        mem_send(5'd13);
        mem_send(5'd14);
        mem_send(5'd15);
        mem_send(5'h10);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        model_reset();
        count_busy(n);
        chk("cl_sweep_len",  32'(n), 32'd16);
        chk("cl_out_valid",  32'(bus.out_valid), 32'd0);
        step();
        bus.mem_valid = 1'b1;
        bus.mem_lit   = 5'd9;
        bus.clear     = 1'b1;
        @(negedge clk);
        chk("clear_wins", 32'(bus.mem_ready), 32'd0);
        step();
        bus.clear     = 1'b0;
        bus.mem_valid = 1'b0;
        count_busy(n);
        chk("cl2_sweep_len", 32'(n), 32'd16);
        step();
        bus.out_ready = 1'b1;
        n0 = n_out;
        mem_send(5'd13);
        repeat (3) step();
        chk("cl_new_again", 32'(n_out - n0), 32'd1);
        chk("cl_drain", 32'(sb_q.size()), 32'd0);

        // Reset mid-RUN with pending outputs
        bus.mem_done = 1'b1;
        repeat (2) step();
        bus.out_ready = 1'b0;
        eng_send(0, 5'd2);
        eng_send(1, 5'd3);
        bus.mem_done = 1'b0;
        rst = 1'b0;
        #1;
        chk("rr_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rr_rst_busy",      32'(bus.busy),      32'd1);
        model_reset();
        step();
        rst = 1'b1;
        count_busy(n);
        chk("rr_rst_sweep_len", 32'(n), 32'd16);
        step();
        bus.out_ready = 1'b1;
        n0 = n_out;
        mem_send(5'd2);
        mem_send(5'd3);
        repeat (3) step();
        chk("rr_rst_new_again", 32'(n_out - n0), 32'd2);
        chk("rr_rst_drain", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
